// File: rtl/bsg_imul_iterative_if.sv
// Request/result channel of the iterative multiplier: v/ready_and request side, v/yumi result side.
// master drives requests and consumes results; slave is the multiplier.
interface bsg_imul_iterative_if #(
    parameter int width_p = 32
);
    logic               v_i;
    logic               ready_and_o;
    logic [width_p-1:0] opA_i;
    logic [width_p-1:0] opB_i;
    logic               signed_i;
    logic               gets_high_part_i;
    logic               v_o;
    logic [width_p-1:0] result_o;
    logic               yumi_i;

    modport master (
        output v_i, opA_i, opB_i, signed_i, gets_high_part_i, yumi_i,
        input  ready_and_o, v_o, result_o
    );

    modport slave (
        input  v_i, opA_i, opB_i, signed_i, gets_high_part_i, yumi_i,
        output ready_and_o, v_o, result_o
    );
endinterface

// File: rtl/bsg_imul_iterative.sv
// Iterative shift-add multiplier on operand magnitudes, one multiplier bit per cycle,
// with a final two's-complement fix-up; returns the low or high product word.
module bsg_imul_iterative #(
    parameter int width_p = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    bsg_imul_iterative_if.slave  bus
);
    localparam int cnt_w = $clog2(width_p);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        ADJ  = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e               state_r, state_n;
    logic [2*width_p-1:0] product_r;
    logic [width_p-1:0]   mcand_r;
    logic [width_p-1:0]   mplier_r;
    logic [cnt_w-1:0]     count_r;
    logic                 neg_r;
    logic                 high_r;
    logic                 accept;
    logic                 last_calc;
    logic [width_p:0]     sum;

    function automatic logic [width_p-1:0] magnitude(input logic [width_p-1:0] op,
                                                     input logic               sgn);
        return (sgn & op[width_p-1]) ? -op : op;
    endfunction

    assign accept    = bus.v_i & (state_r == IDLE);
    assign last_calc = (count_r == cnt_w'(width_p - 1));
    // Upper product half plus the multiplicand, keeping the carry as bit width_p.
    assign sum       = {1'b0, product_r[2*width_p-1:width_p]}
                     + {1'b0, (mplier_r[0] ? mcand_r : '0)};

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk_i) begin
        if (reset_i) state_r <= IDLE;
        else         state_r <= state_n;
    end

    // NOTE: every always_comb output gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        state_n         = state_r;
        bus.ready_and_o = 1'b0;
        bus.v_o         = 1'b0;
        unique case (state_r)
            IDLE: begin
                bus.ready_and_o = 1'b1;
                if (bus.v_i) state_n = CALC;
            end
            CALC: if (last_calc) state_n = ADJ;
            ADJ:  state_n = DONE;
            DONE: begin
                bus.v_o = 1'b1;
                if (bus.yumi_i) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: only registers visible at the outputs (product, counter, mode flags)
    // are reset; the operand registers are always loaded at accept before use.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            product_r <= '0;
            count_r   <= '0;
            neg_r     <= 1'b0;
            high_r    <= 1'b0;
        end else if (accept) begin
            product_r <= '0;
            count_r   <= '0;
            neg_r     <= bus.signed_i & (bus.opA_i[width_p-1] ^ bus.opB_i[width_p-1]);
            high_r    <= bus.gets_high_part_i;
        end else if (state_r == CALC) begin
            product_r <= {sum, product_r[width_p-1:1]};
            count_r   <= count_r + cnt_w'(1);
        end else if (state_r == ADJ && neg_r) begin
            product_r <= -product_r;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            mcand_r  <= magnitude(bus.opA_i, bus.signed_i);
            mplier_r <= magnitude(bus.opB_i, bus.signed_i);
        end else if (state_r == CALC) begin
            mplier_r <= mplier_r >> 1;
        end
    end

    assign bus.result_o = high_r ? product_r[2*width_p-1:width_p] : product_r[width_p-1:0];
endmodule

// File: tb/tb_bsg_imul_iterative.sv
// Self-checking bench for bsg_imul_iterative: directed corner products, busy/handshake
// behaviour, mid-operation reset and randomized pairs against a 64-bit arithmetic model.
module tb_bsg_imul_iterative;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bsg_imul_iterative_if #(.width_p(W)) bus ();

    bsg_imul_iterative #(.width_p(W)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Consumer must never take a result that is not being offered.
    always @(posedge clk) begin
        if (bus.yumi_i) check("yumi_while_v_o_low", {63'd0, bus.v_o}, 64'd1);
    end

    function automatic logic [W-1:0] golden(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic sgn, input logic hi);
        logic [63:0] ea, eb, p;
        ea = sgn ? {{32{a[W-1]}}, a} : {32'd0, a};
        eb = sgn ? {{32{b[W-1]}}, b} : {32'd0, b};
        p  = ea * eb;
        return hi ? p[63:32] : p[31:0];
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // Issues one request, waits for the result, holds yumi off for ydelay cycles.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sgn, input logic hi, input bit toggle,
                          input int ydelay, output logic [W-1:0] res,
                          output int lat, output bit stable, output bit busy_ok);
        int guard;
        res = '0; lat = 0; stable = 1'b1; busy_ok = 1'b1;
        @(negedge clk);
        bus.v_i = 1'b1; bus.opA_i = a; bus.opB_i = b;
        bus.signed_i = sgn; bus.gets_high_part_i = hi;
        guard = 0;
        while (!bus.ready_and_o && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.ready_and_o) begin
            check("accept_timeout", 64'd0, 64'd1);
            bus.v_i = 1'b0;
            return;
        end
        do begin
            @(negedge clk);
            lat++;
            if (toggle) begin
                bus.v_i = lat[0];
                bus.opA_i = $urandom; bus.opB_i = $urandom;
                bus.signed_i = 1'($urandom); bus.gets_high_part_i = 1'($urandom);
            end else begin
                bus.v_i = 1'b0;
            end
            if (bus.ready_and_o) busy_ok = 1'b0;
        end while (!bus.v_o && lat < 200);
        bus.v_i = 1'b0;
        if (!bus.v_o) begin
            check("result_timeout", 64'd0, 64'd1);
            return;
        end
        res = bus.result_o;
        repeat (ydelay) begin
            @(negedge clk);
            if (bus.result_o !== res || !bus.v_o) stable = 1'b0;
        end
        bus.yumi_i = 1'b1;
        @(negedge clk);
        bus.yumi_i = 1'b0;
        check("idle_after_yumi", {62'd0, bus.ready_and_o, bus.v_o}, 64'd2);
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sgn;
        logic         hi;
        logic [W-1:0] exp;
        string        tag;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [W-1:0] res, a, b;
        int           lat;
        bit           stable, busy_ok, saw_v;
        logic         sgn, hi;

        reset = 1'b1;
        bus.v_i = 1'b0; bus.opA_i = '0; bus.opB_i = '0;
        bus.signed_i = 1'b0; bus.gets_high_part_i = 1'b0; bus.yumi_i = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_outputs", {bus.ready_and_o, bus.v_o, bus.result_o}, {2'b10, 32'd0});

        vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0001, "u_ff_lo"});
        vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFE, "u_ff_hi"});
        vecs.push_back('{32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFEB, "s_m3x7_lo"});
        vecs.push_back('{32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFF, "s_m3x7_hi"});
        vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 32'h4000_0000, "s_min2_hi"});
        vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 32'h0000_0000, "s_min2_lo"});
        vecs.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_0000, "s_minxm1_hi"});
        vecs.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0000, "s_minxm1_lo"});
        vecs.push_back('{32'h0000_0000, 32'hFFFF_FFF0, 1'b1, 1'b1, 32'h0000_0000, "s_zero_neg"});

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].hi, 1'b0, 0, res, lat, stable, busy_ok);
            check(vecs[i].tag, {32'd0, res}, {32'd0, vecs[i].exp});
            if (i == 2) check("latency_m3x7", 64'(lat), 64'(W + 2));
        end

        // Busy period with noisy requests, slow consumer.
        a = 32'h0001_E240; b = 32'hFFFF_FD4A;
        run_op(a, b, 1'b1, 1'b0, 1'b1, 5, res, lat, stable, busy_ok);
        check("busy_result", {32'd0, res}, {32'd0, golden(a, b, 1'b1, 1'b0)});
        check("busy_result_stable", {63'd0, stable}, 64'd1);
        check("busy_not_ready", {63'd0, busy_ok}, 64'd1);

        // Reset in the 10th CALC cycle.
        @(negedge clk);
        bus.v_i = 1'b1; bus.opA_i = 32'd1234; bus.opB_i = 32'd5678;
        bus.signed_i = 1'b0; bus.gets_high_part_i = 1'b0;
        @(negedge clk);
        bus.v_i = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_reset_outputs", {bus.ready_and_o, bus.v_o, bus.result_o}, {2'b10, 32'd0});
        saw_v = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.v_o) saw_v = 1'b1;
        end
        check("mid_reset_no_result", {63'd0, saw_v}, 64'd0);
        run_op(32'd6, 32'd7, 1'b0, 1'b0, 1'b0, 0, res, lat, stable, busy_ok);
        check("after_reset_6x7", {32'd0, res}, 64'd42);

        // Randomized pairs, consumer takes results immediately.
        for (int n = 0; n < 1000; n++) begin
            a = pick_operand(); b = pick_operand();
            sgn = 1'($urandom); hi = 1'($urandom);
            run_op(a, b, sgn, hi, 1'b0, 0, res, lat, stable, busy_ok);
            check("rand_product", {32'd0, res}, {32'd0, golden(a, b, sgn, hi)});
            check("rand_latency", 64'(lat), 64'(W + 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
